// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// if_fetch_unit_pkg : shared fetch-stage types and constants
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

    // Redirect targets are word aligned by dropping the low two bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_npc_sel.sv
// ============================================================================
// if_npc_sel : next-PC priority mux (branch > jump > stall > sequential)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module if_npc_sel
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic [31:0] pc_q,
    input  logic        stall,
    input  logic        flush_b,
    input  logic [31:0] br_target,
    input  logic        flush_jump,
    input  logic [31:0] jmp_target,
    output logic [31:0] npc,
    output logic        redirect
);

    assign redirect = flush_b | flush_jump;

    always_comb begin
        npc = pc_q + PC_STEP;
        if (flush_b) begin
            npc = align_word(br_target);
        end else if (flush_jump) begin
            npc = align_word(jmp_target);
        end else if (stall) begin
            npc = pc_q;
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit : instruction fetch stage driving a synchronous IROM.
// Optional trace outputs (inst_valid_IF_out, fetch_cnt) under IF_TRACE_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        nop_data,
    input  logic        Flush_B,
    input  logic [31:0] br_target,
    input  logic        Flush_jump,
    input  logic [31:0] jmp_target,
    output logic [31:0] irom_addr,
    output logic        irom_en,
    input  logic [31:0] irom_data,
    output logic [31:0] pc_IF_out,
    output logic [31:0] pc4_IF_out,
    output logic [31:0] inst_IF_out
`ifdef IF_TRACE_EN
    ,
    output logic        inst_valid_IF_out,
    output logic [31:0] fetch_cnt
`endif
);

    fetch_state_t state, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_inst, hold_d;
    logic [31:0]  npc;
    logic         redirect;

    if_npc_sel #(
        .PC_STEP (PC_STEP)
    ) u_npc_sel (
        .pc_q       (pc_q),
        .stall      (nop_data),
        .flush_b    (Flush_B),
        .br_target  (br_target),
        .flush_jump (Flush_jump),
        .jmp_target (jmp_target),
        .npc        (npc),
        .redirect   (redirect)
    );

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state     <= ST_BOOT;
            pc_q      <= RESET_PC;
            hold_inst <= NOP_INST;
        end else begin
            state     <= state_d;
            pc_q      <= pc_d;
            hold_inst <= hold_d;
        end
    end

    always_comb begin
        state_d     = state;
        pc_d        = pc_q;
        hold_d      = hold_inst;
        irom_addr   = npc;
        irom_en     = 1'b1;
        inst_IF_out = irom_data;
        pc_IF_out   = pc_q;
        case (state)
            ST_BOOT: begin
                irom_addr   = RESET_PC;
                inst_IF_out = NOP_INST;
                pc_d        = RESET_PC;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                pc_d = npc;
                // Capture the word now, the IROM output is not valid while disabled.
                if (nop_data && !redirect) begin
                    hold_d  = irom_data;
                    irom_en = 1'b0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                inst_IF_out = hold_inst;
                pc_d        = npc;
                if (nop_data && !redirect) begin
                    irom_en = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign pc4_IF_out = pc_IF_out + PC_STEP;

`ifdef IF_TRACE_EN
    logic [31:0] fetch_cnt_q;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            fetch_cnt_q <= 32'd0;
        end else if (state == ST_RUN && !nop_data && !redirect) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt         = fetch_cnt_q;
    assign inst_valid_IF_out = (state != ST_BOOT) && !redirect;
`endif

endmodule

`default_nettype wire
